// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants,
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } uart_state_t;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// 8N1/8N2 serial transmitter paced by the shared baud_tick, with a one-entry
// holding register so the next byte can be queued during a frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned DIVIDER   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    uart_state_t state;
    logic [7:0]  hold_reg;
    logic        hold_full;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_cnt;
    logic        stop_cnt;
    logic        frame_end;
    logic        load;

    assign tx_ready  = ~hold_full;
    assign tx_busy   = (state != IDLE);
    assign frame_end = baud_tick && (state == STOP) && (stop_cnt == STOP_LAST);
    // A queued byte starts either from IDLE or straight out of the last stop bit.
    assign load      = hold_full && ((baud_tick && (state == IDLE)) || frame_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (tx_valid && !hold_full) begin
            hold_reg  <= tx_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            tx_out    <= IDLE_LEVEL;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= frame_end;
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        tx_out <= IDLE_LEVEL;
                        if (load) begin
                            shift_reg <= hold_reg;
                            tx_out    <= ~IDLE_LEVEL;
                            state     <= START;
                        end
                    end
                    START: begin
                        tx_out  <= shift_reg[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt != BIT_LAST) begin
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx_out    <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 3'd1;
                        end else begin
                            tx_out   <= IDLE_LEVEL;
                            stop_cnt <= 1'b0;
                            state    <= STOP;
                        end
                    end
                    STOP: begin
                        if (stop_cnt != STOP_LAST) begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end else if (load) begin
                            shift_reg <= hold_reg;
                            tx_out    <= ~IDLE_LEVEL;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        tx_out <= IDLE_LEVEL;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

    // Clocks since the last baud_tick, saturating at DIVIDER.
    int unsigned tick_gap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_gap <= DIVIDER;
        end else if (baud_tick) begin
            tick_gap <= 1;
        end else if (tick_gap < DIVIDER) begin
            tick_gap <= tick_gap + 1;
        end
    end

    a_tick_single: assert property (@(posedge clk) disable iff (!rst_n)
        baud_tick |=> !baud_tick);
    a_tick_spacing: assert property (@(posedge clk) disable iff (!rst_n)
        baud_tick |-> tick_gap >= DIVIDER);

endmodule
